// File: rtl/mux_pkg.sv
// mux_pkg: shared types and constants for mux_reg_pipe (state enum, clog2, reset values)
package mux_pkg;
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
      return r;
   endfunction
   localparam state_e STATE_RST    = EMPTY;
   localparam logic   IN_READY_RST = 1'b1;
   localparam logic   SEL_ERR_RST  = 1'b0;
endpackage

// File: rtl/mux_reg_pipe_if.sv
// mux_reg_pipe_if: select/handshake bundle for mux_reg_pipe
//   in_data/sel/in_valid/in_ready : upstream offer of N_IN words plus index
//   out_data/out_valid/out_ready  : downstream delivery of the selected word
//   sel_err/sel_err_clr           : sticky range flag, present only with MUX_SEL_CHECK_EN
//   slave = the block, master = the environment driving it
interface mux_reg_pipe_if #(parameter int DATA_W = 32, parameter int N_IN = 9);
   localparam int SEL_W = mux_pkg::clog2(N_IN);
   logic [N_IN*DATA_W-1:0] in_data;
   logic [SEL_W-1:0]       sel;
   logic                   in_valid;
   logic                   in_ready;
   logic [DATA_W-1:0]      out_data;
   logic                   out_valid;
   logic                   out_ready;
`ifdef MUX_SEL_CHECK_EN
   logic                   sel_err;
   logic                   sel_err_clr;
   modport slave  (input in_data, sel, in_valid, out_ready, sel_err_clr,
                   output in_ready, out_data, out_valid, sel_err);
   modport master (output in_data, sel, in_valid, out_ready, sel_err_clr,
                   input in_ready, out_data, out_valid, sel_err);
`else
   modport slave  (input in_data, sel, in_valid, out_ready,
                   output in_ready, out_data, out_valid);
   modport master (output in_data, sel, in_valid, out_ready,
                   input in_ready, out_data, out_valid);
`endif
endinterface

// File: rtl/mux_sel_comb.sv
// mux_sel_comb: combinational N_IN:1 word select with out-of-range rule
//   in_data : flattened words, word i at [i*DATA_W +: DATA_W]
//   sel     : index
//   word    : selected word (last word when out of range, or 0 with MUX_SEL_CHECK_EN)
//   sel_bad : sel >= N_IN, only with MUX_SEL_CHECK_EN
module mux_sel_comb import mux_pkg::*; #(
   parameter int DATA_W = 32,
   parameter int N_IN = 9,
   localparam int SEL_W = clog2(N_IN)
) (
   input  logic [N_IN*DATA_W-1:0] in_data,
   input  logic [SEL_W-1:0]       sel,
`ifdef MUX_SEL_CHECK_EN
   output logic                   sel_bad,
`endif
   output logic [DATA_W-1:0]      word
);
   logic [DATA_W-1:0] words [N_IN];
   logic bad;
   for (genvar i = 0; i < N_IN; i++) begin : g_w
      assign words[i] = in_data[i*DATA_W +: DATA_W];
   end
   // a power-of-two N_IN leaves no unused sel codes
   if ((1 << SEL_W) == N_IN) begin : g_pow2
      assign bad = 1'b0;
   end else begin : g_rng
      localparam logic [SEL_W:0] N_LIM = (SEL_W+1)'(N_IN);
      assign bad = {1'b0, sel} >= N_LIM;
   end
`ifdef MUX_SEL_CHECK_EN
   assign sel_bad = bad;
   assign word = bad ? '0 : words[sel];
`else
   localparam logic [SEL_W-1:0] LAST = SEL_W'(N_IN - 1);
   assign word = words[bad ? LAST : sel];
`endif
endmodule

// File: rtl/mux_reg_pipe.sv
// mux_reg_pipe: registered N_IN:1 word select with ready/valid handshake and one skid slot
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mux_reg_pipe_if slave (select input, output handshake, optional sel_err)
//   MUX_SEL_CHECK_EN : out-of-range sel delivers 0 and sets sticky sel_err
module mux_reg_pipe import mux_pkg::*; #(
   parameter int DATA_W = 32,
   parameter int N_IN = 9
) (
   input logic            clk,
   input logic            rst_n,
   mux_reg_pipe_if.slave  bus
);
   state_e state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d, sel_word;
   logic in_ready_q, in_ready_d, acc, con;
`ifdef MUX_SEL_CHECK_EN
   logic sel_bad, sel_err_q, sel_err_d;
`endif
   mux_sel_comb #(.DATA_W(DATA_W), .N_IN(N_IN)) u_sel (
      .in_data(bus.in_data),
      .sel(bus.sel),
`ifdef MUX_SEL_CHECK_EN
      .sel_bad(sel_bad),
`endif
      .word(sel_word)
   );
   always_comb begin
      acc = bus.in_valid && in_ready_q;
      con = (state_q != EMPTY) && bus.out_ready;
      state_d = state_q == EMPTY ? (acc ? ONE : EMPTY)
              : state_q == ONE   ? (acc && !con ? FULL : !acc && con ? EMPTY : ONE)
              : (con ? ONE : FULL);
      // main takes the new word when empty or when it is drained on the same edge
      main_d = (state_q == FULL && con) ? skid_q
             : (acc && (state_q == EMPTY || con)) ? sel_word : main_q;
      skid_d = (acc && state_q == ONE && !con) ? sel_word : skid_q;
      in_ready_d = state_d != FULL;
`ifdef MUX_SEL_CHECK_EN
      sel_err_d = (acc && sel_bad) ? 1'b1 : bus.sel_err_clr ? 1'b0 : sel_err_q;
`endif
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= STATE_RST;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= IN_READY_RST;
`ifdef MUX_SEL_CHECK_EN
         sel_err_q  <= SEL_ERR_RST;
`endif
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
`ifdef MUX_SEL_CHECK_EN
         sel_err_q  <= sel_err_d;
`endif
      end
   end
   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = state_q != EMPTY;
   assign bus.out_data  = main_q;
`ifdef MUX_SEL_CHECK_EN
   assign bus.sel_err   = sel_err_q;
`endif
endmodule

// File: tb/tb_mux_reg_pipe.sv
// tb_mux_reg_pipe: scoreboard bench for mux_reg_pipe at 32x9 and 8x4
module tb_mux_reg_pipe;
   localparam int DW = 32, N = 9, DW2 = 8, N2 = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   mux_reg_pipe_if #(.DATA_W(DW), .N_IN(N)) bus_a ();
   mux_reg_pipe_if #(.DATA_W(DW2), .N_IN(N2)) bus_b ();
   mux_reg_pipe #(.DATA_W(DW), .N_IN(N)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   mux_reg_pipe #(.DATA_W(DW2), .N_IN(N2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

   int tests = 0, fails = 0;
   logic [DW-1:0] q_a[$];
   logic [DW2-1:0] q_b[$];
   logic [DW-1:0] words_a [N];
   logic [DW2-1:0] words_b [N2];
`ifdef MUX_SEL_CHECK_EN
   bit err_m = 1'b0;
`endif

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // reference select rule: in range -> that word, otherwise last word (or 0 when checked)
   function automatic logic [DW-1:0] exp_a(input int s);
      if (s < N) return words_a[s];
`ifdef MUX_SEL_CHECK_EN
      return '0;
`else
      return words_a[N-1];
`endif
   endfunction

   task automatic set_words();
      for (int i = 0; i < N; i++) bus_a.in_data[i*DW +: DW] = words_a[i];
      for (int i = 0; i < N2; i++) bus_b.in_data[i*DW2 +: DW2] = words_b[i];
   endtask

   // monitors: the queues hold exactly what each DUT should be holding, oldest first
   always @(negedge clk) if (rst_n) begin
      chk("a_out_valid", 64'(bus_a.out_valid), 64'(q_a.size() != 0));
      if (bus_a.out_valid && q_a.size() != 0) begin
         chk("a_out_data", 64'(bus_a.out_data), 64'(q_a[0]));
         if (bus_a.out_ready) void'(q_a.pop_front());
      end
   end
   always @(negedge clk) if (rst_n) begin
      chk("b_out_valid", 64'(bus_b.out_valid), 64'(q_b.size() != 0));
      if (bus_b.out_valid && q_b.size() != 0) begin
         chk("b_out_data", 64'(bus_b.out_data), 64'(q_b[0]));
         if (bus_b.out_ready) void'(q_b.pop_front());
      end
   end

   // called just after a rising edge; drives one cycle and commits accepts after the next edge
   task automatic step(input bit v, input logic [3:0] s, input bit ordy);
      bit acc_a, acc_b;
      logic [DW-1:0] ea;
      logic [DW2-1:0] eb;
      chk("a_in_ready", 64'(bus_a.in_ready), 64'(q_a.size() < 2));
      chk("b_in_ready", 64'(bus_b.in_ready), 64'(q_b.size() < 2));
`ifdef MUX_SEL_CHECK_EN
      chk("a_sel_err", 64'(bus_a.sel_err), 64'(err_m));
      chk("b_sel_err", 64'(bus_b.sel_err), 64'(0));
`endif
      set_words();
      bus_a.in_valid = v;
      bus_b.in_valid = v;
      bus_a.sel = s;
      bus_b.sel = s[1:0];
      bus_a.out_ready = ordy;
      bus_b.out_ready = ordy;
      acc_a = v && q_a.size() < 2;
      acc_b = v && q_b.size() < 2;
      ea = exp_a(int'(s));
      eb = words_b[s[1:0]];
      @(posedge clk);
      #2;
      if (acc_a) q_a.push_back(ea);
      if (acc_b) q_b.push_back(eb);
`ifdef MUX_SEL_CHECK_EN
      err_m = (acc_a && int'(s) >= N) ? 1'b1 : bus_a.sel_err_clr ? 1'b0 : err_m;
`endif
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("a_rst_valid", 64'(bus_a.out_valid), 64'(0));
      chk("a_rst_ready", 64'(bus_a.in_ready), 64'(1));
      chk("a_rst_data", 64'(bus_a.out_data), 64'(0));
      chk("b_rst_valid", 64'(bus_b.out_valid), 64'(0));
      chk("b_rst_ready", 64'(bus_b.in_ready), 64'(1));
      chk("b_rst_data", 64'(bus_b.out_data), 64'(0));
`ifdef MUX_SEL_CHECK_EN
      chk("a_rst_sel_err", 64'(bus_a.sel_err), 64'(0));
      err_m = 1'b0;
`endif
      q_a.delete();
      q_b.delete();
      bus_a.in_valid = 1'b0;
      bus_b.in_valid = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      bus_a.in_valid = 1'b0; bus_b.in_valid = 1'b0;
      bus_a.out_ready = 1'b0; bus_b.out_ready = 1'b0;
      bus_a.sel = '0; bus_b.sel = '0;
`ifdef MUX_SEL_CHECK_EN
      bus_a.sel_err_clr = 1'b0; bus_b.sel_err_clr = 1'b0;
`endif
      for (int i = 0; i < N; i++) words_a[i] = 32'hA000_0000 + DW'(i);
      for (int i = 0; i < N2; i++) words_b[i] = 8'h50 + DW2'(i);
      set_words();
      #3;
      do_reset();
      // streaming, one word per cycle
      for (int i = 0; i < N; i++) step(1'b1, 4'(i), 1'b1);
      repeat (2) step(1'b0, 4'd0, 1'b1);
      // back-pressure: fill to FULL, offer a third word that must be refused
      step(1'b1, 4'd3, 1'b0);
      step(1'b1, 4'd5, 1'b0);
      step(1'b1, 4'd7, 1'b0);
      step(1'b0, 4'd0, 1'b0);
      repeat (3) step(1'b0, 4'd0, 1'b1);
      // out-of-range selects
      step(1'b1, 4'hF, 1'b1);
      step(1'b1, 4'hC, 1'b1);
      step(1'b0, 4'd0, 1'b1);
`ifdef MUX_SEL_CHECK_EN
      bus_a.sel_err_clr = 1'b1;
      step(1'b0, 4'd0, 1'b1);
      step(1'b1, 4'hC, 1'b1);
      bus_a.sel_err_clr = 1'b0;
      step(1'b0, 4'd0, 1'b1);
`endif
      // reset in the middle of a stalled transfer
      step(1'b1, 4'd1, 1'b0);
      step(1'b1, 4'd2, 1'b0);
      do_reset();
      step(1'b1, 4'd4, 1'b1);
      repeat (2) step(1'b0, 4'd0, 1'b1);
      // randomized traffic
      repeat (400) begin
         for (int i = 0; i < N; i++) words_a[i] = $urandom;
         for (int i = 0; i < N2; i++) words_b[i] = 8'($urandom);
`ifdef MUX_SEL_CHECK_EN
         bus_a.sel_err_clr = ($urandom_range(0, 7) == 0);
`endif
         step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom_range(0, 2) != 0);
      end
`ifdef MUX_SEL_CHECK_EN
      bus_a.sel_err_clr = 1'b0;
`endif
      repeat (4) step(1'b0, 4'd0, 1'b1);
      chk("a_drained", 64'(q_a.size()), 64'(0));
      chk("b_drained", 64'(q_b.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
